// File: rtl/list_sum_datapath_pkg.sv
// Shared constants for the linked-list summation engine.
// Used by both the datapath and the control FSM.
package list_sum_datapath_pkg;

  // Default word and address widths
  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 4;

  // The head node of every list lives at this address
  localparam int HEAD_ADDR = 0;

  // A_SEL encoding: read the node value (at NEXT) or its pointer (at NEXT+1)
  localparam logic ASEL_VALUE = 1'b0;
  localparam logic ASEL_PTR   = 1'b1;

endpackage

// File: rtl/list_sum_datapath_mem.sv
// Node memory: 2**AW x DW words, one synchronous write port and one
// asynchronous read port. A same-cycle read of the written address sees
// the old contents. Contents are deliberately not touched by reset.
module list_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Host write port, committed on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read; the control FSM depends on seeing data in-cycle
  assign rdata = mem[raddr];

endmodule

// File: rtl/list_sum_datapath.sv
// Datapath of the linked-list summation engine: node memory, SUM and NEXT
// registers, read-address mux, adder with sticky carry flag, and the result
// capture taken while the FSM holds DONE.
//
// Control inputs are plain level-sensitive load enables and mux selects that
// are sampled on every rising edge; there is no handshake. Any combination is
// applied literally.
module list_sum_datapath
  import list_sum_datapath_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LD_SUM,
  input  logic          LD_NEXT,
  input  logic          SUM_SEL,
  input  logic          NEXT_SEL,
  input  logic          A_SEL,
  input  logic          DONE,
  output logic          next_zero,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          overflow
);

  localparam logic [AW-1:0] HEAD     = AW'(HEAD_ADDR);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [DW-1:0] sum_q;
  logic [AW-1:0] next_q;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rdata;
  logic [DW:0]   sum_wide;
  logic          sum_init;
  logic          sum_accum;

  // Pointer word sits right after the value word; the +1 wraps at AW bits
  assign rd_addr = (A_SEL == ASEL_PTR) ? (next_q + ADDR_ONE) : next_q;

  list_mem #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .we   (host_we),
    .waddr(host_addr),
    .wdata(host_wdata),
    .raddr(rd_addr),
    .rdata(rdata)
  );

  // One extra bit on the adder so the carry-out feeds the overflow flag
  assign sum_wide  = {1'b0, sum_q} + {1'b0, rdata};
  assign sum_init  = LD_SUM && !SUM_SEL;
  assign sum_accum = LD_SUM && SUM_SEL;

  assign next_zero = (next_q == HEAD);

  // SUM register: clear on init, accumulate modulo 2**DW otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (sum_accum) begin
      sum_q <= sum_wide[DW-1:0];
    end else if (sum_init) begin
      sum_q <= '0;
    end
  end

  // NEXT register: back to the head, or follow the pointer just read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_q <= HEAD;
    end else if (LD_NEXT) begin
      next_q <= NEXT_SEL ? rdata[AW-1:0] : HEAD;
    end
  end

  // Sticky carry flag: set by any carrying accumulate, cleared by init
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (sum_accum && sum_wide[DW]) begin
      overflow <= 1'b1;
    end else if (sum_init) begin
      overflow <= 1'b0;
    end
  end

  // Result capture; DONE beats a coincident init so the finished sum is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else if (DONE) begin
      result       <= sum_q;
      result_valid <= 1'b1;
    end else if (sum_init) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_list_sum_datapath.sv
// Bench for list_sum_datapath: directed scenarios plus random linked lists.
// The reference model walks the list in a local memory image and computes
// the true integer sum; the DUT result and carry flag are judged from that.
module tb_list_sum_datapath;
  import list_sum_datapath_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          LD_SUM, LD_NEXT, SUM_SEL, NEXT_SEL, A_SEL, DONE;
  logic          next_zero;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          overflow;

  list_sum_datapath #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .LD_SUM      (LD_SUM),
    .LD_NEXT     (LD_NEXT),
    .SUM_SEL     (SUM_SEL),
    .NEXT_SEL    (NEXT_SEL),
    .A_SEL       (A_SEL),
    .DONE        (DONE),
    .next_zero   (next_zero),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .result      (result),
    .result_valid(result_valid),
    .overflow    (overflow)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic ls, input logic ln, input logic ss,
                      input logic ns, input logic as, input logic dn);
    LD_SUM = ls; LD_NEXT = ln; SUM_SEL = ss; NEXT_SEL = ns; A_SEL = as; DONE = dn;
    @(posedge clk); #1;
    LD_SUM = 0; LD_NEXT = 0; SUM_SEL = 0; NEXT_SEL = 0; A_SEL = 0; DONE = 0;
  endtask

  task automatic host_write(input int addr, input logic [DW-1:0] data);
    host_we = 1'b1; host_addr = AW'(addr); host_wdata = data;
    @(posedge clk); #1;
    host_we = 1'b0;
    mem_m[addr] = data;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sum"}, 32'(dut.sum_q), 0);
    chk({tag, "_next"}, 32'(dut.next_q), 0);
    chk({tag, "_next_zero"}, 32'(next_zero), 1);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_valid"}, 32'(result_valid), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  // Walk the list held in mem_m from the head and drive the FSM sequence
  task automatic run_list(input string tag);
    int            total;
    int            addr;
    int            n;
    logic [DW-1:0] w;
    logic [AW-1:0] p;
    total = 0; addr = 0; n = 0;
    step(1, 1, 0, 0, ASEL_VALUE, 0);
    chk({tag, "_init_sum"}, 32'(dut.sum_q), 0);
    chk({tag, "_init_ov"}, 32'(overflow), 0);
    chk({tag, "_init_valid"}, 32'(result_valid), 0);
    do begin
      total += int'(mem_m[addr]);
      step(1, 0, 1, 0, ASEL_VALUE, 0);
      chk($sformatf("%s_sum%0d", tag, n), 32'(dut.sum_q), 32'(total % 256));
      chk($sformatf("%s_ov%0d", tag, n), 32'(overflow), 32'(total > 255));
      w = mem_m[(addr + 1) % DEPTH];
      p = w[AW-1:0];
      step(0, 1, 0, 1, ASEL_PTR, 0);
      chk($sformatf("%s_next%0d", tag, n), 32'(dut.next_q), 32'(p));
      chk($sformatf("%s_nz%0d", tag, n), 32'(next_zero), 32'(p == 0));
      addr = int'(p);
      n++;
    end while (addr != 0 && n < DEPTH);
    exp_q.push_back(DW'(total % 256));
    step(0, 0, 0, 0, ASEL_VALUE, 1);
    chk({tag, "_result"}, 32'(result), 32'(exp_q.pop_front()));
    chk({tag, "_valid"}, 32'(result_valid), 1);
    chk({tag, "_ov_done"}, 32'(overflow), 32'(total > 255));
  endtask

  task automatic load_normal_list();
    for (int k = 0; k < DEPTH; k++) host_write(k, 8'd0);
    host_write(0, 8'd5); host_write(1, 8'd4);
    host_write(4, 8'd7); host_write(5, 8'd8);
    host_write(8, 8'd3); host_write(9, 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] old_v;
    logic [DW-1:0] new_v;
    int            pool [7];
    int            addrs [8];
    int            k;
    int            tmp;
    int            j;

    rst = 1'b1;
    LD_SUM = 0; LD_NEXT = 0; SUM_SEL = 0; NEXT_SEL = 0; A_SEL = 0; DONE = 0;
    host_we = 0; host_addr = '0; host_wdata = '0;
    #3;
    check_reset_state("por");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Normal traversal with literal expected values
    load_normal_list();
    step(1, 1, 0, 0, ASEL_VALUE, 0);
    chk("nt_init_nz", 32'(next_zero), 1);
    step(1, 0, 1, 0, ASEL_VALUE, 0); chk("nt_sum1", 32'(dut.sum_q), 5);
    step(0, 1, 0, 1, ASEL_PTR, 0);   chk("nt_next1", 32'(dut.next_q), 4);
    chk("nt_nz1", 32'(next_zero), 0);
    step(1, 0, 1, 0, ASEL_VALUE, 0); chk("nt_sum2", 32'(dut.sum_q), 12);
    step(0, 1, 0, 1, ASEL_PTR, 0);   chk("nt_next2", 32'(dut.next_q), 8);
    step(1, 0, 1, 0, ASEL_VALUE, 0); chk("nt_sum3", 32'(dut.sum_q), 15);
    chk("nt_nz_pre", 32'(next_zero), 0);
    step(0, 1, 0, 1, ASEL_PTR, 0);   chk("nt_next3", 32'(dut.next_q), 0);
    chk("nt_nz3", 32'(next_zero), 1);
    step(0, 0, 0, 0, ASEL_VALUE, 1);
    chk("nt_result", 32'(result), 15);
    chk("nt_valid", 32'(result_valid), 1);
    chk("nt_ov", 32'(overflow), 0);

    // Asynchronous reset in the middle of a clock period
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    #1; rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-traversal, then a clean re-run
    step(1, 1, 0, 0, ASEL_VALUE, 0);
    step(1, 0, 1, 0, ASEL_VALUE, 0);
    step(0, 1, 0, 1, ASEL_PTR, 0);
    step(1, 0, 1, 0, ASEL_VALUE, 0);
    step(0, 1, 0, 1, ASEL_PTR, 0);
    chk("mid_sum_pre", 32'(dut.sum_q), 12);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_sum", 32'(dut.sum_q), 0);
    chk("mid_next", 32'(dut.next_q), 0);
    chk("mid_valid", 32'(result_valid), 0);
    chk("mid_nz", 32'(next_zero), 1);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_mem0", 32'(dut.rdata), 5);
    run_list("rerun");

    // Overflow and its clearing by the next init
    for (int a = 0; a < DEPTH; a++) host_write(a, 8'd0);
    host_write(0, 8'd200); host_write(1, 8'd2);
    host_write(2, 8'd100); host_write(3, 8'd0);
    run_list("ovf");
    chk("ovf_result44", 32'(result), 44);
    step(1, 1, 0, 0, ASEL_VALUE, 0);
    chk("ovf_cleared", 32'(overflow), 0);
    chk("ovf_valid_cleared", 32'(result_valid), 0);
    chk("ovf_result_held", 32'(result), 44);

    // Pointer wrap: NEXT=15 with A_SEL=1 reads address 0
    host_write(0, 8'hA5); host_write(1, 8'h0F); host_write(15, 8'h11);
    step(1, 1, 0, 0, ASEL_VALUE, 0);
    step(0, 1, 0, 1, ASEL_PTR, 0);
    chk("wrap_next", 32'(dut.next_q), 15);
    A_SEL = ASEL_PTR; #1;
    chk("wrap_rdata", 32'(dut.rdata), 32'(mem_m[0]));
    step(1, 0, 1, 0, ASEL_PTR, 0);
    chk("wrap_sum", 32'(dut.sum_q), 32'(mem_m[0]));

    // Same-address write during read: old value summed, new visible next cycle
    step(1, 1, 0, 0, ASEL_VALUE, 0);
    old_v = mem_m[0];
    new_v = DW'($urandom_range(0, 255));
    host_we = 1'b1; host_addr = '0; host_wdata = new_v;
    step(1, 0, 1, 0, ASEL_VALUE, 0);
    host_we = 1'b0; mem_m[0] = new_v;
    chk("rw_old_summed", 32'(dut.sum_q), 32'(old_v));
    chk("rw_new_visible", 32'(dut.rdata), 32'(new_v));
    step(1, 0, 1, 0, ASEL_VALUE, 0);
    chk("rw_sum2", 32'(dut.sum_q), 32'((int'(old_v) + int'(new_v)) % 256));

    // Hold with changing rdata, then DONE beats a coincident init
    load_normal_list();
    step(1, 1, 0, 0, ASEL_VALUE, 0);
    step(1, 0, 1, 0, ASEL_VALUE, 0);
    step(0, 1, 0, 1, ASEL_PTR, 0);
    for (int c = 0; c < 5; c++) begin
      A_SEL = c[0];
      host_write(4 + (c % 2), DW'($urandom_range(0, 255)));
      chk($sformatf("hold_sum%0d", c), 32'(dut.sum_q), 5);
      chk($sformatf("hold_next%0d", c), 32'(dut.next_q), 4);
    end
    step(1, 0, 0, 0, ASEL_VALUE, 1);
    chk("prio_result", 32'(result), 5);
    chk("prio_valid", 32'(result_valid), 1);
    chk("prio_sum", 32'(dut.sum_q), 0);
    chk("prio_next", 32'(dut.next_q), 4);

    // Random acyclic lists
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < DEPTH; a++) host_write(a, DW'($urandom_range(0, 255)));
      for (int q = 0; q < 7; q++) pool[q] = 2 * (q + 1);
      for (int q = 6; q > 0; q--) begin
        j = $urandom_range(0, q);
        tmp = pool[q]; pool[q] = pool[j]; pool[j] = tmp;
      end
      k = $urandom_range(1, 6);
      addrs[0] = 0;
      for (int q = 1; q < k; q++) addrs[q] = pool[q - 1];
      for (int q = 0; q < k; q++) begin
        host_write(addrs[q], DW'($urandom_range(0, 255)));
        tmp = (q < k - 1) ? addrs[q + 1] : 0;
        host_write(addrs[q] + 1, {4'($urandom_range(0, 15)), 4'(tmp)});
      end
      run_list($sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
